sseg_scan_driver: RTL

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_pkg.sv | 53 +++++
 rtl/sseg_decode.sv | 11 +
 rtl/sseg_scan_driver.sv | 119 +++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared code points and active-low segment patterns ({g,f,e,d,c,b,a}) for the
// eight-digit seven-segment scan driver.
package sseg_pkg;

  localparam logic [4:0] CODE_ZERO  = 5'h00;
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;
  localparam logic [4:0] CODE_H     = 5'h12;
  localparam logic [4:0] CODE_L     = 5'h13;
  localparam logic [4:0] CODE_P     = 5'h14;
  localparam logic [4:0] CODE_R     = 5'h15;
  localparam logic [4:0] CODE_U     = 5'h16;
  localparam logic [4:0] CODE_O     = 5'h17;

  localparam logic [6:0] SEG_X0 = 7'b1000000;
  localparam logic [6:0] SEG_X1 = 7'b1111001;
  localparam logic [6:0] SEG_X2 = 7'b0100100;
  localparam logic [6:0] SEG_X3 = 7'b0110000;
  localparam logic [6:0] SEG_X4 = 7'b0011001;
  localparam logic [6:0] SEG_X5 = 7'b0010010;
  localparam logic [6:0] SEG_X6 = 7'b0000010;
  localparam logic [6:0] SEG_X7 = 7'b1111000;
  localparam logic [6:0] SEG_X8 = 7'b0000000;
  localparam logic [6:0] SEG_X9 = 7'b0010000;
  localparam logic [6:0] SEG_XA = 7'b0001000;
  localparam logic [6:0] SEG_XB = 7'b0000011;
  localparam logic [6:0] SEG_XC = 7'b1000110;
  localparam logic [6:0] SEG_XD = 7'b0100001;
  localparam logic [6:0] SEG_XE = 7'b0000110;
  localparam logic [6:0] SEG_XF = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_LH    = 7'b0001001;
  localparam logic [6:0] SEG_LL    = 7'b1000111;
  localparam logic [6:0] SEG_LP    = 7'b0001100;
  localparam logic [6:0] SEG_LR    = 7'b0101111;
  localparam logic [6:0] SEG_LU    = 7'b1000001;
  localparam logic [6:0] SEG_LO    = 7'b0100011;

  // Indexed directly by the 5-bit code; entry 0 is the least significant slice.
  localparam logic [31:0][6:0] SEG_TABLE = {
    {8{SEG_BLANK}},
    SEG_LO, SEG_LU, SEG_LR, SEG_LP, SEG_LL, SEG_LH, SEG_DASH, SEG_BLANK,
    SEG_XF, SEG_XE, SEG_XD, SEG_XC, SEG_XB, SEG_XA, SEG_X9, SEG_X8,
    SEG_X7, SEG_X6, SEG_X5, SEG_X4, SEG_X3, SEG_X2, SEG_X1, SEG_X0
  };

  function automatic logic code_is_blank(input logic [4:0] code);
    return (code == CODE_BLANK) || (code[4:3] == 2'b11);
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational 5-bit digit code to active-low seven-segment pattern decoder.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_TABLE[code_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with frame-atomic snapshot.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV = 100000  // clk cycles per digit slot, at least 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dig7,
  input  logic [4:0] dig6,
  input  logic [4:0] dig5,
  input  logic [4:0] dig4,
  input  logic [4:0] dig3,
  input  logic [4:0] dig2,
  input  logic [4:0] dig1,
  input  logic [4:0] dig0,
  input  logic [7:0] dp,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][4:0] dig_in;
  logic [7:0][4:0] snap_code_q, snap_code_d;
  logic [7:0]      snap_dp_q, snap_dp_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_n_q, dp_n_d;
  logic [4:0]      cur_code;
  logic [4:0]      disp_code;
  logic [6:0]      dec_seg;

  assign dig_in = {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};

  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    snap_code_d = snap_code_q;
    snap_dp_d   = snap_dp_q;
    // Capture only on the 7->0 wrap so a whole frame shows one coherent set.
    if (tick && (idx_q == 3'd7)) begin
      snap_code_d = dig_in;
      snap_dp_d   = dp;
    end
  end

  assign cur_code = snap_code_q[idx_q];

`ifdef SSEG_LZ_BLANK_EN
  logic [7:0] lz_blank;

  // Walk from the top digit down; a zero is suppressed only while everything
  // above it renders blank and its own decimal point is off.
  always_comb begin : lz_chain
    logic hi_blank;
    hi_blank = 1'b1;
    lz_blank = '0;
    for (int i = 7; i >= 1; i--) begin
      lz_blank[i] = hi_blank && (snap_code_q[i] == CODE_ZERO) && !snap_dp_q[i];
      hi_blank    = lz_blank[i] || (hi_blank && code_is_blank(snap_code_q[i]));
    end
  end

  assign disp_code = lz_blank[idx_q] ? CODE_BLANK : cur_code;
`else
  assign disp_code = cur_code;
`endif

  sseg_decode u_decode (
    .code_i  (disp_code),
    .seg_n_o (dec_seg)
  );

  // Count zero is the first cycle of a slot: all anodes off to avoid ghosting.
  always_comb begin
    if (cnt_q == '0) begin
      an_d   = 8'hFF;
      seg_d  = SEG_BLANK;
      dp_n_d = 1'b1;
    end else begin
      an_d   = ~(8'h01 << idx_q);
      seg_d  = dec_seg;
      dp_n_d = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      snap_code_q <= {8{CODE_BLANK}};
      snap_dp_q   <= '0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
      dp_n_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snap_code_q <= snap_code_d;
      snap_dp_q   <= snap_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule
